// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit for the EX stage (shift-add multiply, restoring divide).
// Optional MULDIV_FAST_MUL_EN: multiplies complete through a single-cycle `*` product.
module ex_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             start,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam int CW = $clog2(WIDTH);

  logic [1:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic [2:0]       r_op;
  logic             r_neg;
  logic [WIDTH-1:0] r_hi, r_lo, r_b;
  logic [WIDTH-1:0] r_result;
  logic             r_done;

  logic             w_is_div, w_a_sgn, w_b_sgn, w_sa, w_sb, w_neg;
  logic             w_dz, w_ovf;
  logic [WIDTH-1:0] w_mag_a, w_mag_b, w_spec_res;
  logic [WIDTH:0]   w_madd, w_shift, w_diff;
  logic [WIDTH-1:0] w_hi_nx, w_lo_nx, w_fin;
  logic [2*WIDTH-1:0] w_prod, w_prod_s;

  function automatic logic [WIDTH-1:0] f_mul_sel(input logic [2:0] op, input logic [2*WIDTH-1:0] p);
    f_mul_sel = (op[1:0] == 2'b00) ? p[WIDTH-1:0] : p[2*WIDTH-1:WIDTH];
  endfunction

  // Operand decode: which sources are signed, magnitudes and the final negate flag
  assign w_is_div = funct3[2];
  assign w_a_sgn  = (funct3 == 3'b001) | (funct3 == 3'b010) | (funct3[2] & ~funct3[0]);
  assign w_b_sgn  = (funct3 == 3'b001) | (funct3[2] & ~funct3[0]);
  assign w_sa     = w_a_sgn & src_a[WIDTH-1];
  assign w_sb     = w_b_sgn & src_b[WIDTH-1];
  assign w_mag_a  = w_sa ? -src_a : src_a;
  assign w_mag_b  = w_sb ? -src_b : src_b;
  assign w_neg    = (w_is_div & funct3[1]) ? w_sa : (w_sa ^ w_sb);

  assign w_dz  = w_is_div & (src_b == '0);
  assign w_ovf = w_is_div & ~funct3[0] & (src_a == {1'b1, {(WIDTH-1){1'b0}}}) & (src_b == '1);
  assign w_spec_res = w_dz ? (funct3[1] ? src_a : '1) : (funct3[1] ? '0 : src_a);

  // One iteration: r_hi is partial product / remainder, r_lo is multiplier / dividend->quotient
  assign w_madd  = {1'b0, r_hi} + {1'b0, r_b & {WIDTH{r_lo[0]}}};
  assign w_shift = {r_hi, r_lo[WIDTH-1]};
  assign w_diff  = w_shift - {1'b0, r_b};

  always_comb begin
    w_hi_nx = '0;
    w_lo_nx = '0;
    if (r_op[2]) begin
      w_hi_nx = w_diff[WIDTH] ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
      w_lo_nx = {r_lo[WIDTH-2:0], ~w_diff[WIDTH]};
    end else begin
      w_hi_nx = w_madd[WIDTH:1];
      w_lo_nx = {w_madd[0], r_lo[WIDTH-1:1]};
    end
  end

  assign w_prod   = {w_hi_nx, w_lo_nx};
  assign w_prod_s = r_neg ? -w_prod : w_prod;

  always_comb begin
    w_fin = '0;
    case (r_op[2:1])
      2'b10:   w_fin = r_neg ? -w_lo_nx : w_lo_nx;
      2'b11:   w_fin = r_neg ? -w_hi_nx : w_hi_nx;
      default: w_fin = f_mul_sel(r_op, w_prod_s);
    endcase
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [2*WIDTH-1:0] w_fprod, w_fprod_s;
  assign w_fprod   = {{WIDTH{1'b0}}, w_mag_a} * {{WIDTH{1'b0}}, w_mag_b};
  assign w_fprod_s = w_neg ? -w_fprod : w_fprod;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_op     <= '0;
      r_neg    <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (flush) begin
        r_state <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: if (start) begin
            r_op  <= funct3;
            r_neg <= w_neg;
            r_cnt <= '0;
            r_hi  <= '0;
            r_lo  <= w_mag_a;
            r_b   <= w_mag_b;
            if (w_dz | w_ovf) begin
              r_result <= w_spec_res;
              r_done   <= 1'b1;
              r_state  <= S_DONE;
            end
`ifdef MULDIV_FAST_MUL_EN
            else if (!w_is_div) begin
              r_result <= f_mul_sel(funct3, w_fprod_s);
              r_done   <= 1'b1;
              r_state  <= S_DONE;
            end
`endif
            else begin
              r_state <= S_RUN;
            end
          end
          S_RUN: begin
            r_hi  <= w_hi_nx;
            r_lo  <= w_lo_nx;
            r_cnt <= r_cnt + CW'(1);
            if (r_cnt == CW'(WIDTH-1)) begin
              r_result <= w_fin;
              r_done   <= 1'b1;
              r_state  <= S_DONE;
            end
          end
          // start seen here is still the retiring instruction
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign busy   = ((r_state == S_IDLE) & start & ~flush) | (r_state == S_RUN);
  assign done   = r_done;
  assign result = r_result;
endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: directed vector table, multi-cycle corner sequences,
// and random ops checked against a plain-arithmetic RV32M reference.
module tb_ex_muldiv;
  logic        clk, rstn, flush, start;
  logic [2:0]  funct3;
  logic [31:0] src_a, src_b;
  logic        busy, done;
  logic [31:0] result;

  int n_chk = 0;
  int n_fail = 0;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MB = 1;
`else
  localparam int MB = 33;
`endif

  ex_muldiv #(.WIDTH(32)) dut (
    .clk(clk), .rstn(rstn), .flush(flush), .start(start), .funct3(funct3),
    .src_a(src_a), .src_b(src_b), .busy(busy), .done(done), .result(result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          bsy;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint      as, bs, p;
    logic [63:0] pu;
    as = longint'(signed'(a));
    bs = longint'(signed'(b));
    pu = {32'h0, a} * {32'h0, b};
    case (f)
      3'b000: begin p = as * bs; return p[31:0]; end
      3'b001: begin p = as * bs; return p[63:32]; end
      3'b010: begin p = as * longint'(b); return p[63:32]; end
      3'b011: return pu[63:32];
      3'b100: begin if (b == 0) return 32'hFFFF_FFFF; p = as / bs; return p[31:0]; end
      3'b101: begin if (b == 0) return 32'hFFFF_FFFF; return a / b; end
      3'b110: begin if (b == 0) return a; p = as % bs; return p[31:0]; end
      default: begin if (b == 0) return a; return a % b; end
    endcase
  endfunction

  function automatic int ref_busy(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
    if (!f[2]) return MB;
    return 33;
  endfunction

  // Issue one op, count busy cycles, capture the done-cycle result, then check pulse width
  task automatic run_op(input string nm, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input int exp_busy,
                        input bit hold);
    int bc; bit got; logic [31:0] res; logic bz;
    bc = 0; got = 0; res = '0; bz = 1'b0;
    @(negedge clk);
    start = 1'b1; funct3 = f; src_a = a; src_b = b;
    for (int c = 0; c < 100 && !got; c++) begin
      #1;
      if (done) begin
        got = 1; res = result; bz = busy;
      end else begin
        if (busy) bc++;
        @(negedge clk);
        src_a = $urandom; src_b = $urandom;
      end
    end
    chk({nm, " done seen"}, 32'(got), 32'd1);
    if (got) begin
      chk({nm, " result"}, res, exp_res);
      chk({nm, " busy cycles"}, 32'(bc), 32'(exp_busy));
      chk({nm, " busy in done"}, 32'(bz), 32'd0);
    end
    if (!hold) start = 1'b0;
    @(negedge clk);
    start = 1'b0;
    #1;
    chk({nm, " done pulse width"}, 32'(done), 32'd0);
    if (hold) begin
      for (int c = 0; c < 3; c++) begin
        @(negedge clk); #1;
        chk({nm, " no second done"}, {31'd0, done | busy}, 32'd0);
      end
    end
  endtask

  vec_t vt[14];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int dc;
    logic [2:0]  rf;
    logic [31:0] ra, rb;
    logic [31:0] corner[6];

    vt[0]  = '{"MUL 7*-3",       3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, MB};
    vt[1]  = '{"MULH min*min",   3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MB};
    vt[2]  = '{"MULHU max*max",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MB};
    vt[3]  = '{"MULHSU -1*2",    3'b010, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, MB};
    vt[4]  = '{"DIV ovf",        3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
    vt[5]  = '{"REM ovf",        3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1};
    vt[6]  = '{"DIVU by 0",      3'b101, 32'h1234,      32'h0,         32'hFFFF_FFFF, 1};
    vt[7]  = '{"REMU by 0",      3'b111, 32'h1234,      32'h0,         32'h1234,      1};
    vt[8]  = '{"DIV -7/2",       3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33};
    vt[9]  = '{"REM -7/2",       3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33};
    vt[10] = '{"DIV by 0",       3'b100, 32'd5,         32'h0,         32'hFFFF_FFFF, 1};
    vt[11] = '{"REM by 0",       3'b110, 32'hFFFF_FFF9, 32'h0,         32'hFFFF_FFF9, 1};
    vt[12] = '{"DIVU 256/7",     3'b101, 32'd256,       32'd7,         32'h24,        33};
    vt[13] = '{"REMU 256/7",     3'b111, 32'd256,       32'd7,         32'h4,         33};

    corner = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h2};

    rstn = 1'b0; flush = 1'b0; start = 1'b0; funct3 = '0; src_a = '0; src_b = '0;
    #23;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset result", result, 32'd0);
    @(negedge clk); rstn = 1'b1;

    foreach (vt[i]) run_op(vt[i].nm, vt[i].f, vt[i].a, vt[i].b, vt[i].exp, vt[i].bsy, 1'b0);

    // Flush mid-divide: no done, then a full-latency multiply
    @(negedge clk);
    start = 1'b1; funct3 = 3'b101; src_a = 32'hDEAD_BEEF; src_b = 32'd3;
    @(negedge clk);
    repeat (10) @(negedge clk);
    #1;
    chk("flush busy in RUN", 32'(busy), 32'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; start = 1'b0;
    #1;
    chk("flush busy after", 32'(busy), 32'd0);
    dc = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk); #1;
      if (done) dc++;
    end
    chk("flush no done", 32'(dc), 32'd0);
    run_op("MUL 3*5 after flush", 3'b000, 32'd3, 32'd5, 32'd15, MB, 1'b0);

    // Start held through DONE
    run_op("DIVU hold", 3'b101, 32'd1000, 32'd10, 32'd100, 33, 1'b1);
    run_op("MULHU hold", 3'b011, 32'hFFFF_FFFF, 32'd2, 32'd1, MB, 1'b1);

    // Reset in the middle of an iterative divide
    @(negedge clk);
    start = 1'b1; funct3 = 3'b100; src_a = 32'h7654_3210; src_b = 32'd9;
    repeat (6) @(negedge clk);
    rstn = 1'b0; start = 1'b0;
    #1;
    chk("midrun reset busy", 32'(busy), 32'd0);
    chk("midrun reset done", 32'(done), 32'd0);
    chk("midrun reset result", result, 32'd0);
    @(negedge clk); rstn = 1'b1;
    run_op("DIV after reset", 3'b100, 32'h7654_3210, 32'd9, 32'h7654_3210 / 32'd9, 33, 1'b0);

    for (int i = 0; i < 60; i++) begin
      rf = 3'($urandom_range(0, 7));
      ra = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
      rb = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
      if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(8, 30);
      run_op($sformatf("rand%0d f%0d", i, rf), rf, ra, rb, ref_res(rf, ra, rb),
             ref_busy(rf, ra, rb), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
